// File: rtl/fifo_unpacker.sv
// fifo_unpacker: read-side stage for a first-word-fall-through FIFO.
// Pops WIDTH-bit words and emits them as WIDTH/CHUNK chunks over a
// valid/ready interface, least-significant chunk first. The next word is
// fetched on the same cycle the last chunk of the current word is accepted,
// so a non-empty FIFO and a ready consumer give one chunk per cycle.
// Optional feature macro: FIFO_UNPACKER_LAST_EN adds out_last, which marks
// the final chunk of each word.
module fifo_unpacker #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHUNK-1:0] out_data,
  output logic             busy
`ifdef FIFO_UNPACKER_LAST_EN
  ,
  output logic             out_last
`endif
);

  localparam int RATIO = WIDTH / CHUNK;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Reject geometries that cannot be split into at least two whole chunks.
  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0) || (RATIO < 2)) begin : g_bad_param
    $error("fifo_unpacker: WIDTH must be a multiple of CHUNK with WIDTH/CHUNK >= 2");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   wbuf_r;
  logic [IDX_W-1:0]   idx_r;
  logic               out_valid_r;
  logic               busy_r;
  logic [CHUNK-1:0]   out_data_r;

  logic               accept_s;
  logic               last_s;
  logic               load_s;
  logic [IDX_W-1:0]   idx_inc_s;

  // Select chunk number i of a word; chunk 0 is the least-significant one.
  function automatic logic [CHUNK-1:0] chunk_of(input logic [WIDTH-1:0] w,
                                                input logic [IDX_W-1:0] i);
    logic [CHUNK-1:0] c;
    c = {CHUNK{1'b0}};
    for (int k = 0; k < RATIO; k++) begin
      if (i == IDX_W'(k)) begin
        c = w[k*CHUNK +: CHUNK];
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  // Handshake decode and the load decision that drives the FIFO pop.
  always_comb begin
    accept_s  = out_valid_r & out_ready;
    last_s    = (idx_r == LAST_IDX);
    idx_inc_s = idx_r + IDX_ONE;
    load_s    = ~fifo_empty & ((state_r == IDLE) | (accept_s & last_s));
  end

  // The pop strobe is held low while reset is asserted.
  assign fifo_read = load_s & reset;

  // Word capture, chunk stepping and the registered output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      wbuf_r      <= {WIDTH{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_data_r  <= {CHUNK{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (load_s) begin
            state_r     <= SEND;
            wbuf_r      <= fifo_data;
            idx_r       <= {IDX_W{1'b0}};
            out_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            out_data_r  <= fifo_data[CHUNK-1:0];
          end else begin
            state_r <= IDLE;
          end
        end
        SEND: begin
          if (load_s) begin
            // Last chunk accepted with another word waiting: chain straight on.
            state_r     <= SEND;
            wbuf_r      <= fifo_data;
            idx_r       <= {IDX_W{1'b0}};
            out_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            out_data_r  <= fifo_data[CHUNK-1:0];
          end else if (accept_s && last_s) begin
            // Word finished and nothing queued: park, showing chunk 0 as idle data.
            state_r     <= IDLE;
            idx_r       <= {IDX_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            out_data_r  <= wbuf_r[CHUNK-1:0];
          end else if (accept_s) begin
            idx_r      <= idx_inc_s;
            out_data_r <= chunk_of(wbuf_r, idx_inc_s);
          end else begin
            // Stalled: everything holds until the consumer accepts.
            state_r <= SEND;
          end
        end
        default: begin
          state_r     <= IDLE;
          idx_r       <= {IDX_W{1'b0}};
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_data  = out_data_r;

`ifdef FIFO_UNPACKER_LAST_EN
  logic out_last_r;

  // Flag the final chunk of a word, updated in step with out_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_last_r <= 1'b0;
    end else if (load_s) begin
      out_last_r <= 1'b0;
    end else if (accept_s) begin
      out_last_r <= ~last_s & (idx_inc_s == LAST_IDX);
    end else begin
      out_last_r <= out_last_r;
    end
  end

  assign out_last = out_last_r;
`endif

endmodule

// File: doc/fifo_unpacker.md
# fifo_unpacker

Downstream read-side stage for the team's `Fifo` block. It pops WIDTH-bit words from the FIFO's read port and emits each word as WIDTH/CHUNK narrower chunks over a valid/ready interface, least-significant chunk first. Use it wherever a wide FIFO feeds a narrow consumer, such as a serial link, a byte bus or a debug port. It fetches the next word on the same cycle the last chunk is accepted, so sustained throughput is one chunk per cycle with no bubbles.

## Interface
- WIDTH, 8, FIFO word width in bits; must match the upstream FIFO.
- CHUNK, 2, output chunk width in bits.
  - WIDTH must be an exact multiple of CHUNK, and RATIO = WIDTH/CHUNK must be ≥ 2.
  - Elaboration fails with `$error` otherwise.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  WIDTH  FIFO head word; valid whenever fifo_empty=0 (first-word-fall-through).
- fifo_read  output  1  pop strobe to the FIFO; combinational.
- out_valid  output  1  out_data holds a valid chunk.
- out_ready  input  1  consumer accepts the chunk this cycle.
- out_data  output  CHUNK  current chunk.
- busy  output  1  a word is held (state SEND).
- out_last  output  1  only with FIFO_UNPACKER_LAST_EN; marks the final chunk of a word.

## Operation
- State held:
  - state IDLE/SEND;
  - word register wbuf[WIDTH-1:0];
  - chunk index idx, width clog2(RATIO).
- Handshake: a chunk transfers on any cycle where out_valid=1 and out_ready=1 ("accept").
- Load condition: load = ~fifo_empty & (state==IDLE | (accept & idx==RATIO-1)).
- fifo_read = load. It is forced to 0 while reset is asserted.
- On load at a clock edge:
  - wbuf <= fifo_data;
  - idx <= 0;
  - state <= SEND.
- IDLE:
  - out_valid=0, busy=0.
  - Goes to SEND on load.
- SEND:
  - out_valid=1, busy=1.
  - out_data = wbuf[idx*CHUNK +: CHUNK].
  - On accept with idx<RATIO-1: idx <= idx+1.
  - On accept with idx==RATIO-1 and no load: state <= IDLE, idx <= 0.
  - On accept with idx==RATIO-1 and load: next word loaded; stays in SEND.
- Output stability: once out_valid=1, out_data and out_valid stay stable until accept. There is no retraction.
- fifo_read depends combinationally on out_ready; the consumer must not derive out_ready from fifo_read.
- fifo_data is sampled only on the edge where fifo_read=1. Changes at any other time are ignored.
- When out_valid=0, out_data is driven as the current wbuf chunk (don't-care). It is 0 after reset.

## Timing
- Reset values: state=IDLE, idx=0, wbuf=0, out_valid=0, out_data=0, busy=0, fifo_read=0, out_last=0.
- Reset mid-word: the held word is discarded with no further chunks. FIFO contents are untouched.
- Latency: fifo_empty falls in cycle N while IDLE → fifo_read=1 in cycle N → out_valid=1 with chunk 0 in cycle N+1.
- Chunks of one word appear on RATIO consecutive accepts.
- A word takes a minimum of RATIO cycles. Sustained rate is one chunk per cycle while the FIFO is non-empty and out_ready=1.
- FIFO empty at the last accept: out_valid drops the next cycle.
- A word arriving later restarts with one cycle of latency, as from IDLE.
- out_ready=0 stalls indefinitely with no state change, and fifo_read stays 0.
- Pops happen only when the FIFO is non-empty, so a pop is never issued against an empty FIFO.

## Configuration
- FIFO_UNPACKER_LAST_EN defined:
  - adds the out_last port, out_last = out_valid & (idx==RATIO-1);
  - it is stable under the same rules as out_data.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then push one word 0xB4 with WIDTH=8, CHUNK=2, out_ready=1:
  - exactly one fifo_read pulse;
  - chunks 0,1,3,2 on consecutive cycles;
  - busy high for 4 cycles, then IDLE.
- Back-to-back words 0x1B, 0xE4 preloaded, out_ready=1:
  - 8 consecutive valid cycles with chunks 3,2,1,0,0,1,2,3;
  - second fifo_read in the same cycle as the first word's last accept.
- Backpressure: word 0x1B, out_ready toggling 1,0,0,1,...:
  - out_data holds each chunk while stalled;
  - fifo_read never asserts during a stall;
  - chunk order is unchanged.
- Reset deasserted to asserted after 2 of 4 chunks of 0xFF:
  - out_valid=0 and out_data=0 immediately (asynchronous);
  - next pushed word 0x00 produces four 0 chunks.
- Empty FIFO with fifo_data driven with garbage for 20 cycles: out_valid, fifo_read and busy stay 0.
- With FIFO_UNPACKER_LAST_EN, WIDTH=16, CHUNK=4, word 0xABCD:
  - chunks D,C,B,A;
  - out_last=1 only with chunk A.
